div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle iterative divide unit with its own sequencing FSM; sits beside the EX-stage ALU and serves DIV/DIVU.
- Latches operands when a divide reaches EX and holds the pipeline through DivStall for the iteration count.
- Presents the quotient and remainder for the HILO write, and aborts cleanly on an EX flush or exception.

Parameters:
WIDTH, 32, operand/result width; iteration count = WIDTH; counter width = clog2(WIDTH).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
StartE  input  1  divide instruction present in EX (held while it stays in EX)
SignedE  input  1  1 = DIV (signed), 0 = DIVU
SrcAE  input  WIDTH  dividend
SrcBE  input  WIDTH  divisor
FlushE  input  1  annul the EX instruction (exception/flush)
AdvanceE  input  1  EX stage advances this cycle (no external EX stall)
DivStall  output  1  stall request to hazard unit
DivDone  output  1  result valid; drives the HILO write enable for the divide
HiE  output  WIDTH  remainder
LoE  output  WIDTH  quotient

Behaviour:
- Reset is asynchronous and active-high. Reset forces state IDLE, counter 0, all internal registers 0, and HiE/LoE = 0. DivStall and DivDone are combinational and read 0 in IDLE.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY when StartE & ~FlushE.
  - Latch |SrcAE| and |SrcBE|. Magnitudes apply only when SignedE, otherwise the raw values are used.
  - Latch qsign = SignedE & (A[msb] ^ B[msb]) and rsign = SignedE & A[msb].
  - Clear the partial remainder and the counter.
- BUSY: one restoring-division step per cycle.
  - Shift {rem,quo} left by 1.
  - If rem >= divisor: rem -= divisor and quo[0] = 1.
  - The counter increments each step. After step WIDTH (counter == WIDTH-1), go to DONE.
- DONE: LoE = qsign ? -quo : quo; HiE = rsign ? -rem : rem. Results are registered and stable throughout DONE.
  - Stay in DONE while ~AdvanceE. StartE is ignored here, so the same instruction never restarts.
  - DONE -> IDLE when AdvanceE.
- DivStall = ~FlushE & ((IDLE & StartE) | BUSY).
- DivDone = (DONE) & ~FlushE.
- Latency: StartE seen in IDLE at cycle T gives DivStall high on cycles T..T+WIDTH (WIDTH+1 cycles). DONE and DivDone occur on cycle T+WIDTH+1, when DivStall is low.
- FlushE in any state: next state is IDLE, the counter clears, and no DivDone is produced. DivStall drops in the same cycle. A new StartE is accepted the cycle after the flush.
- Divisor 0: no trap; normal latency.
  - Unsigned result: LoE = all ones, HiE = dividend.
  - Signed result: the same magnitude result, then the sign fixups.
- Signed overflow 0x80000000 / -1: LoE = 0x80000000, HiE = 0.
- Operand changes on SrcAE/SrcBE after the start cycle have no effect.
- Reset mid-operation: immediate IDLE; no DivDone.

Test Plan:
- Unsigned 100/7, AdvanceE=1: DivStall high exactly 33 cycles from the start cycle; DivDone=1 on cycle 33; LoE=14, HiE=2; IDLE on cycle 34.
- Signed -7/2 (0xFFFFFFF9 / 2): LoE=0xFFFFFFFD, HiE=0xFFFFFFFF. Signed 7/-2: LoE=0xFFFFFFFD, HiE=1.
- Edge operands:
  - DIVU 5/0: LoE=0xFFFFFFFF, HiE=5.
  - DIV 0x80000000 / 0xFFFFFFFF: LoE=0x80000000, HiE=0.
  - DIVU 0xFFFFFFFF/1: LoE=0xFFFFFFFF, HiE=0.
- Abort paths:
  - FlushE on BUSY cycle 10: DivStall=0 that cycle, IDLE next, DivDone never asserts.
  - A following start of 9/3 gives LoE=3, HiE=0 with full latency.
  - rst pulsed mid-BUSY: same abort result.
- AdvanceE low for 3 cycles in DONE, StartE held high:
  - DivDone stays 1 and HiE/LoE stay stable; DivStall stays 0; no restart.
  - IDLE the cycle after AdvanceE=1.

Source files
------------

// File: rtl/div_sequencer.sv
// Iterative restoring divider for DIV/DIVU with its own sequencing FSM.
// It holds the EX stage through DivStall while the iterations run.
// Quotient and remainder are presented on LoE/HiE for the HILO write.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StartE,
  input  logic             SignedE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  input  logic             AdvanceE,
  output logic             DivStall,
  output logic             DivDone,
  output logic [WIDTH-1:0] HiE,
  output logic [WIDTH-1:0] LoE
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [CntW-1:0]  count;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             qSign;
  logic             rSign;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] remStep;
  logic [WIDTH-1:0] quoStep;
  logic             lastStep;
  logic             takeStart;

  assign takeStart = (state == IDLE) && StartE && !FlushE;
  assign lastStep  = (state == BUSY) && (count == CntW'(WIDTH - 1));

  // One restoring step: shift {rem,quo} left and subtract the divisor if it fits.
  // trial is one bit wider because the shifted remainder can exceed WIDTH bits.
  always_comb begin
    trial   = {rem, quo[WIDTH-1]};
    remStep = trial[WIDTH-1:0];
    quoStep = {quo[WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, divisor}) begin
      remStep = WIDTH'(trial - {1'b0, divisor});
      quoStep = {quo[WIDTH-2:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and stall/done decode; a flush annuls everything in the same cycle.
  always_comb begin
    stateNext = state;
    DivStall  = 1'b0;
    DivDone   = 1'b0;
    case (state)
      IDLE: begin
        if (StartE) begin
          DivStall  = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        DivStall = 1'b1;
        if (lastStep) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        DivDone = 1'b1;
        if (AdvanceE) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    if (FlushE) begin
      stateNext = IDLE;
      DivStall  = 1'b0;
      DivDone   = 1'b0;
    end
  end

  // Operand capture, iteration datapath and registered sign-corrected results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      qSign   <= 1'b0;
      rSign   <= 1'b0;
      HiE     <= '0;
      LoE     <= '0;
    end else if (FlushE) begin
      count <= '0;
    end else if (takeStart) begin
      quo     <= (SignedE && SrcAE[WIDTH-1]) ? WIDTH'(-SrcAE) : SrcAE;
      divisor <= (SignedE && SrcBE[WIDTH-1]) ? WIDTH'(-SrcBE) : SrcBE;
      qSign   <= SignedE && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
      rSign   <= SignedE && SrcAE[WIDTH-1];
      rem     <= '0;
      count   <= '0;
    end else if (state == BUSY) begin
      rem   <= remStep;
      quo   <= quoStep;
      count <= count + CntW'(1);
      if (lastStep) begin
        count <= '0;
        LoE   <= qSign ? WIDTH'(-quoStep) : quoStep;
        HiE   <= rSign ? WIDTH'(-remStep) : remStep;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, results, abort and hold paths.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        StartE;
  logic        SignedE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        FlushE;
  logic        AdvanceE;
  logic        DivStall;
  logic        DivDone;
  logic [31:0] HiE;
  logic [31:0] LoE;

  int checkCount;
  int errorCount;

  div_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .StartE   (StartE),
    .SignedE  (SignedE),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
    .FlushE   (FlushE),
    .AdvanceE (AdvanceE),
    .DivStall (DivStall),
    .DivDone  (DivDone),
    .HiE      (HiE),
    .LoE      (LoE)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Run one divide from the start cycle; inputs change at negedge, outputs sampled 1 ns later.
  task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expLo,
                        input logic [31:0] expHi, input int holdCycles);
    int stallCycles;
    int doneAt;
    @(negedge clk);
    SignedE  = sgn;
    SrcAE    = a;
    SrcBE    = b;
    StartE   = 1'b1;
    AdvanceE = (holdCycles == 0);
    stallCycles = 0;
    doneAt      = -1;
    for (int c = 0; c < 60 && doneAt < 0; c++) begin
      #1;
      if (DivDone) begin
        doneAt = c;
      end else begin
        if (DivStall) stallCycles++;
        @(negedge clk);
        if (c == 0) begin
          SrcAE = ~a;
          SrcBE = a ^ b ^ 32'h1;
        end
      end
    end
    checkVal({tag, " stallCycles"}, 32'(stallCycles), 32'd33);
    checkVal({tag, " doneCycle"}, 32'(doneAt), 32'd33);
    checkVal({tag, " stallInDone"}, {31'd0, DivStall}, 32'd0);
    checkVal({tag, " LoE"}, LoE, expLo);
    checkVal({tag, " HiE"}, HiE, expHi);
    for (int h = 1; h <= holdCycles; h++) begin
      @(negedge clk);
      if (h == holdCycles) AdvanceE = 1'b1;
      #1;
      checkVal({tag, " holdDone"}, {31'd0, DivDone}, 32'd1);
      checkVal({tag, " holdStall"}, {31'd0, DivStall}, 32'd0);
      checkVal({tag, " holdLoE"}, LoE, expLo);
      checkVal({tag, " holdHiE"}, HiE, expHi);
    end
    @(negedge clk);
    StartE = 1'b0;
    #1;
    checkVal({tag, " idleDone"}, {31'd0, DivDone}, 32'd0);
    checkVal({tag, " idleStall"}, {31'd0, DivStall}, 32'd0);
  endtask

  // Confirm no DivDone appears over a window after an abort.
  task automatic expectNoDone(input string tag);
    logic sawDone;
    sawDone = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (DivDone) sawDone = 1'b1;
      @(negedge clk);
    end
    checkVal(tag, {31'd0, sawDone}, 32'd0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst      = 1'b1;
    StartE   = 1'b0;
    SignedE  = 1'b0;
    SrcAE    = '0;
    SrcBE    = '0;
    FlushE   = 1'b0;
    AdvanceE = 1'b1;

    #1;
    checkVal("rst DivStall", {31'd0, DivStall}, 32'd0);
    checkVal("rst DivDone", {31'd0, DivDone}, 32'd0);
    checkVal("rst HiE", HiE, 32'd0);
    checkVal("rst LoE", LoE, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    runDiv("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);

    // Flush on BUSY cycle 10.
    @(negedge clk);
    SignedE = 1'b0; SrcAE = 32'd100; SrcBE = 32'd7; StartE = 1'b1; AdvanceE = 1'b1;
    repeat (10) @(negedge clk);
    FlushE = 1'b1;
    #1;
    checkVal("flush DivStall", {31'd0, DivStall}, 32'd0);
    checkVal("flush DivDone", {31'd0, DivDone}, 32'd0);
    @(negedge clk);
    FlushE = 1'b0;
    StartE = 1'b0;
    #1;
    checkVal("flush idleStall", {31'd0, DivStall}, 32'd0);
    @(negedge clk);
    expectNoDone("flush noDone");
    runDiv("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

    // Reset pulsed mid-BUSY.
    @(negedge clk);
    SignedE = 1'b1; SrcAE = 32'd1000; SrcBE = 32'd7; StartE = 1'b1;
    repeat (15) @(negedge clk);
    rst    = 1'b1;
    StartE = 1'b0;
    #1;
    checkVal("rstMid DivStall", {31'd0, DivStall}, 32'd0);
    checkVal("rstMid DivDone", {31'd0, DivDone}, 32'd0);
    checkVal("rstMid LoE", LoE, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expectNoDone("rstMid noDone");
    runDiv("divu 9/3 again", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

    runDiv("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    runDiv("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
    runDiv("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
    runDiv("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, 0);
    runDiv("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
    runDiv("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
    runDiv("divu hold 1000/33", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
